// File: rtl/argon_pkg.sv
// Shared definitions for the Argon memory controller.
//   - state_t       : controller FSM state encoding
//   - SIZE_HALF/WORD: core access-size encoding (i_cpu_size)
//   - ARGON_ADDR_W  : SRAM/core halfword address width
//   - ARGON_MEM_W   : SRAM data width
//   - addr_inc()    : next halfword address, wrapping modulo 2^ARGON_ADDR_W
package argon_pkg;

    localparam int ARGON_ADDR_W = 16;
    localparam int ARGON_MEM_W  = 16;

    localparam logic SIZE_HALF = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // The adder is exactly ARGON_ADDR_W bits wide, so 0xFFFF wraps to 0x0000.
    function automatic logic [ARGON_ADDR_W-1:0] addr_inc(input logic [ARGON_ADDR_W-1:0] a);
        return a + ARGON_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/argon_memory_controller.sv
// argon_memory_controller
// Bridges the Argon core request port to a 16-bit word-addressed synchronous
// SRAM. A 32-bit access becomes two halfword accesses (A, then A+1); a 16-bit
// access touches A only. Read halfwords are assembled and presented to the
// core as one registered 32-bit word.
//
// Ports
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_cpu_address/data        : halfword address A, 32-bit write data
//   i_cpu_re/we/size          : read/write strobes (read wins), size 1=32b 0=16b
//   o_cpu_data                : read result, held until the next read completes
//   o_cpu_busy / o_cpu_idle   : core handshake (combinational)
//   o_mem_addr/wdata/re/we    : registered SRAM command outputs
//   i_mem_rdata               : SRAM read data, READ_LATENCY cycles after o_mem_re
module argon_memory_controller
    import argon_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [ARGON_ADDR_W-1:0] i_cpu_address,
    input  logic [31:0]             i_cpu_data,
    input  logic                    i_cpu_re,
    input  logic                    i_cpu_we,
    input  logic                    i_cpu_size,
    output logic [31:0]             o_cpu_data,
    output logic                    o_cpu_busy,
    output logic                    o_cpu_idle,
    output logic [ARGON_ADDR_W-1:0] o_mem_addr,
    output logic [ARGON_MEM_W-1:0]  o_mem_wdata,
    output logic                    o_mem_re,
    output logic                    o_mem_we,
    input  logic [ARGON_MEM_W-1:0]  i_mem_rdata
);

    localparam logic [2:0] LAT_CNT = 3'(READ_LATENCY);

    state_t                  state_reg, state_next;
    logic [2:0]              cnt_reg, cnt_next;
    logic [ARGON_ADDR_W-1:0] addr_reg, addr_next;
    logic [ARGON_MEM_W-1:0]  hi_wdata_reg, hi_wdata_next;
    logic                    size_reg, size_next;
    logic [ARGON_MEM_W-1:0]  lo_rdata_reg, lo_rdata_next;
    logic [31:0]             cpu_data_reg, cpu_data_next;
    logic [ARGON_ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [ARGON_MEM_W-1:0]  mem_wdata_reg, mem_wdata_next;
    logic                    mem_re_reg, mem_re_next;
    logic                    mem_we_reg, mem_we_next;

    logic req;
    logic lat_hit;

    assign req     = i_cpu_re | i_cpu_we;
    // Counter is cleared on phase entry, so it equals L during the phase's
    // cycle L: the edge ending that cycle is the one that samples the SRAM.
    assign lat_hit = (cnt_reg == LAT_CNT);

    assign o_cpu_busy  = (state_reg == ST_IDLE) ? req : (state_reg != ST_DONE);
    assign o_cpu_idle  = (state_reg == ST_IDLE) & ~req;
    assign o_cpu_data  = cpu_data_reg;
    assign o_mem_addr  = mem_addr_reg;
    assign o_mem_wdata = mem_wdata_reg;
    assign o_mem_re    = mem_re_reg;
    assign o_mem_we    = mem_we_reg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            hi_wdata_reg  <= '0;
            size_reg      <= SIZE_HALF;
            lo_rdata_reg  <= '0;
            cpu_data_reg  <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_re_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            hi_wdata_reg  <= hi_wdata_next;
            size_reg      <= size_next;
            lo_rdata_reg  <= lo_rdata_next;
            cpu_data_reg  <= cpu_data_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_re_reg    <= mem_re_next;
            mem_we_reg    <= mem_we_next;
        end
    end

    // Next-state and registered-output logic. SRAM strobes default low so
    // they last exactly one cycle; address/data hold for the whole phase
    // and are cleared whenever a phase is left for DONE.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = 3'(cnt_reg + 3'd1);
        addr_next      = addr_reg;
        hi_wdata_next  = hi_wdata_reg;
        size_next      = size_reg;
        lo_rdata_next  = lo_rdata_reg;
        cpu_data_next  = cpu_data_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_re_next    = 1'b0;
        mem_we_next    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (req) begin
                    addr_next     = i_cpu_address;
                    hi_wdata_next = i_cpu_data[31:16];
                    size_next     = i_cpu_size;
                    mem_addr_next = i_cpu_address;
                    if (i_cpu_re) begin
                        state_next  = ST_RD_LO;
                        mem_re_next = 1'b1;
                    end else begin
                        state_next     = ST_WR_LO;
                        mem_wdata_next = i_cpu_data[15:0];
                        mem_we_next    = 1'b1;
                    end
                end
            end

            ST_RD_LO: begin
                if (lat_hit) begin
                    if (size_reg == SIZE_WORD) begin
                        // Low half is staged so o_cpu_data changes only
                        // when the whole read completes.
                        lo_rdata_next = i_mem_rdata;
                        state_next    = ST_RD_HI;
                        cnt_next      = '0;
                        mem_addr_next = addr_inc(addr_reg);
                        mem_re_next   = 1'b1;
                    end else begin
                        cpu_data_next = {16'h0000, i_mem_rdata};
                        state_next    = ST_DONE;
                        mem_addr_next = '0;
                    end
                end
            end

            ST_RD_HI: begin
                if (lat_hit) begin
                    cpu_data_next = {i_mem_rdata, lo_rdata_reg};
                    state_next    = ST_DONE;
                    mem_addr_next = '0;
                end
            end

            ST_WR_LO: begin
                if (size_reg == SIZE_WORD) begin
                    state_next     = ST_WR_HI;
                    mem_addr_next  = addr_inc(addr_reg);
                    mem_wdata_next = hi_wdata_reg;
                    mem_we_next    = 1'b1;
                end else begin
                    state_next     = ST_DONE;
                    mem_addr_next  = '0;
                    mem_wdata_next = '0;
                end
            end

            ST_WR_HI: begin
                state_next     = ST_DONE;
                mem_addr_next  = '0;
                mem_wdata_next = '0;
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
